// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU operand controller: forward-select
// encodings, the default register-index width and the scoreboard entry layout.
package alu_ctrl_pkg;

  localparam int DEF_REG_AW = 5;

  // Forward-select encodings for the ALU operand muxes
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_WB    = 2'd3;

  // One tracked downstream instruction; all-zero is a bubble
  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic                  is_load;
    logic [DEF_REG_AW-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/alu_operand_ctrl_if.sv
// RD-stage issue bus and EX-stage operand-select outputs of alu_operand_ctrl.
// master = pipeline side driving the RD-stage instruction, slave = controller.
interface alu_operand_ctrl_if #(parameter int REG_AW = alu_ctrl_pkg::DEF_REG_AW);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_wen;
  logic              id_is_load;
  logic              id_use_imm;
  logic              flush;
  logic              stall;
  logic [1:0]        ex_sel_a;
  logic [1:0]        ex_sel_b;
  logic              ex_imm_sel;
  logic              ex_valid;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_wen, id_is_load, id_use_imm, flush,
    input  stall, ex_sel_a, ex_sel_b, ex_imm_sel, ex_valid
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_wen, id_is_load, id_use_imm, flush,
    output stall, ex_sel_a, ex_sel_b, ex_imm_sel, ex_valid
  );

endinterface

// File: rtl/alu_operand_ctrl_fwd_match.sv
// fwd_match: picks the forward source for one operand index against the
// EX, MEM and WB scoreboard entries. Nearest producer wins; r0 never matches.
module fwd_match
  import alu_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  sb_entry_t         ex_e,
  input  sb_entry_t         mem_e,
  input  sb_entry_t         wb_e,
  output logic [1:0]        sel
);

  // The load flag only matters for stalling, not for choosing the source
  logic unused_load_bits;
  assign unused_load_bits = ex_e.is_load ^ mem_e.is_load ^ wb_e.is_load;

  function automatic logic hit(input sb_entry_t e, input logic [REG_AW-1:0] s);
    return (s != '0) && e.valid && e.wen && (e.rd == s);
  endfunction

  // Priority compare, youngest producer first
  always_comb begin
    sel = FWD_RF;
    if (hit(ex_e, src)) begin
      sel = FWD_EXMEM;
    end else if (hit(mem_e, src)) begin
      sel = FWD_MEMWB;
    end else if (hit(wb_e, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: operand-select scheduler for the EX-stage ALU muxes.
// Tracks EX/MEM/WB destinations in a scoreboard shift register, registers the
// forward selects into EX, raises one-cycle load-use stalls and honours flush.
// Optional: define ALU_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
module alu_operand_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int DEPTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_ctrl_if.slave    bus
`ifdef ALU_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  // sb[0] = EX, sb[1] = MEM, sb[2] = WB
  sb_entry_t  sb [DEPTH];
  sb_entry_t  new_entry;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_use;
  logic       stall_int;
  logic       issue;
  logic [1:0] ex_sel_a_q;
  logic [1:0] ex_sel_b_q;
  logic       ex_imm_sel_q;

  fwd_match #(.REG_AW(REG_AW)) u_match_a (
    .src   (bus.id_rs),
    .ex_e  (sb[0]),
    .mem_e (sb[1]),
    .wb_e  (sb[DEPTH-1]),
    .sel   (sel_a)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_b (
    .src   (bus.id_rt),
    .ex_e  (sb[0]),
    .mem_e (sb[1]),
    .wb_e  (sb[DEPTH-1]),
    .sel   (sel_b)
  );

  // Load-use detection, issue decision and the entry that enters EX next
  always_comb begin
    load_use  = sb[0].is_load &&
                ((sel_a == FWD_EXMEM) || (!bus.id_use_imm && (sel_b == FWD_EXMEM)));
    stall_int = bus.id_valid && !bus.flush && load_use;
    issue     = bus.id_valid && !stall_int && !bus.flush;
    new_entry = '0;
    if (issue) begin
      new_entry.valid   = 1'b1;
      new_entry.wen     = bus.id_wen;
      new_entry.is_load = bus.id_is_load;
      new_entry.rd      = bus.id_rd;
    end
  end

  // Scoreboard shift: a flush only blocks the incoming entry, older ones keep moving
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
    end else begin
      sb[0] <= new_entry;
      for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  // Selects travel into EX with the instruction; bubbles get register-file selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_sel_a_q   <= FWD_RF;
      ex_sel_b_q   <= FWD_RF;
      ex_imm_sel_q <= 1'b0;
    end else begin
      ex_sel_a_q   <= issue ? sel_a : FWD_RF;
      ex_sel_b_q   <= (issue && !bus.id_use_imm) ? sel_b : FWD_RF;
      ex_imm_sel_q <= issue && bus.id_use_imm;
    end
  end

  assign bus.stall      = stall_int;
  assign bus.ex_sel_a   = ex_sel_a_q;
  assign bus.ex_sel_b   = ex_sel_b_q;
  assign bus.ex_imm_sel = ex_imm_sel_q;
  assign bus.ex_valid   = sb[0].valid;

`ifdef ALU_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stall cycles; flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_int && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Testbench for alu_operand_ctrl: directed instruction stream with hand-derived
// expected EX-stage selects queued at issue and compared one clock later.
module tb_alu_operand_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   step;

  alu_operand_ctrl_if #(.REG_AW(5)) bus ();

`ifdef ALU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  alu_operand_ctrl #(.REG_AW(5), .DEPTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       imm_sel;
  } exp_t;

  exp_t exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic collectResult();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput($sformatf("s%0d_queue_empty", step), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput($sformatf("s%0d_ex_valid", step), {31'd0, bus.ex_valid}, {31'd0, e.valid});
      checkOutput($sformatf("s%0d_ex_sel_a", step), {30'd0, bus.ex_sel_a}, {30'd0, e.sel_a});
      checkOutput($sformatf("s%0d_ex_sel_b", step), {30'd0, bus.ex_sel_b}, {30'd0, e.sel_b});
      checkOutput($sformatf("s%0d_ex_imm_sel", step), {31'd0, bus.ex_imm_sel}, {31'd0, e.imm_sel});
    end
  endtask

  // Drive one RD-stage instruction for a cycle, check stall, then check EX after the edge
  task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic wen, input logic is_load,
                               input logic use_imm, input logic flush_in, input logic exp_stall,
                               input logic [1:0] exp_a, input logic [1:0] exp_b);
    exp_t e;
    step++;
    @(negedge clk);
    bus.id_valid   = valid;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = rd;
    bus.id_wen     = wen;
    bus.id_is_load = is_load;
    bus.id_use_imm = use_imm;
    bus.flush      = flush_in;
    #1;
    checkOutput($sformatf("s%0d_stall", step), {31'd0, bus.stall}, {31'd0, exp_stall});
    e.valid   = valid & ~exp_stall & ~flush_in;
    e.sel_a   = e.valid ? exp_a : 2'd0;
    e.sel_b   = (e.valid & ~use_imm) ? exp_b : 2'd0;
    e.imm_sel = e.valid & use_imm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    collectResult();
  endtask

  // lw rX with no tracked sources, then a consumer of rX: one stall, then MEM forward
  task automatic loadUsePair(input logic [4:0] ld_rd);
    applyStimulus(1, 0, 0, ld_rd, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, ld_rd, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(1, ld_rd, 0, 0, 0, 0, 1, 0, 0, 2, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    step     = 0;
    rst_n    = 1'b0;
    bus.id_valid   = 1'b1;
    bus.id_rs      = 5'd3;
    bus.id_rt      = 5'd3;
    bus.id_rd      = 5'd0;
    bus.id_wen     = 1'b0;
    bus.id_is_load = 1'b0;
    bus.id_use_imm = 1'b0;
    bus.flush      = 1'b0;
    #1;
    checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("rst_ex_sel_a", {30'd0, bus.ex_sel_a}, 32'd0);
    checkOutput("rst_ex_sel_b", {30'd0, bus.ex_sel_b}, 32'd0);
    checkOutput("rst_ex_imm_sel", {31'd0, bus.ex_imm_sel}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Args: valid rs rt rd wen load imm flush | stall sel_a sel_b
    applyStimulus(1,  3,  1,  2, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1,  1,  2,  5, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1,  5,  5,  6, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1,  5,  2,  7, 0, 0, 0, 0, 0, 2, 3);
    applyStimulus(1,  7,  6,  0, 1, 0, 0, 0, 0, 0, 2);
    applyStimulus(1,  0,  6,  4, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1,  0,  0,  1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1,  0,  0,  4, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1,  4,  4,  8, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1,  1,  4,  0, 1, 0, 0, 0, 0, 3, 2);
    applyStimulus(1,  0,  0,  3, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1,  1,  0,  7, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1,  7,  0,  8, 1, 0, 1, 0, 1, 0, 0);
    applyStimulus(1,  7,  0,  8, 1, 0, 1, 0, 0, 2, 0);
    applyStimulus(1,  0,  0,  9, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1,  0,  9, 10, 1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1,  0,  9, 10, 1, 0, 0, 0, 0, 0, 2);
    applyStimulus(1, 10,  0, 11, 1, 1, 1, 0, 0, 1, 0);
    applyStimulus(1, 11, 11, 12, 1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 11, 11, 12, 1, 0, 0, 0, 0, 2, 2);
`ifdef ALU_STALL_CNT_EN
    checkOutput("stall_cnt_three", {16'd0, stall_cnt}, 32'd3);
`endif
    applyStimulus(1,  0,  0, 13, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 12, 13, 14, 1, 0, 1, 0, 0, 2, 0);
    applyStimulus(1,  0,  0,  9, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1,  9,  0, 15, 1, 0, 1, 1, 0, 0, 0);
    applyStimulus(1,  9,  9, 16, 1, 0, 0, 0, 0, 2, 2);
    applyStimulus(1,  9, 16, 17, 1, 0, 0, 0, 0, 3, 1);
    applyStimulus(1,  0,  0, 18, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 18, 17,  0, 1, 0, 0, 0, 0, 0, 2);
    applyStimulus(0,  5,  5,  5, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1,  0,  0,  3, 1, 1, 1, 0, 0, 0, 0);

    // Reset in the middle of a load-use pair
    @(negedge clk);
    bus.id_valid   = 1'b1;
    bus.id_rs      = 5'd3;
    bus.id_rt      = 5'd0;
    bus.id_rd      = 5'd5;
    bus.id_wen     = 1'b1;
    bus.id_is_load = 1'b0;
    bus.id_use_imm = 1'b1;
    bus.flush      = 1'b0;
    #1;
    checkOutput("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("mid_rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("mid_rst_ex_imm_sel", {31'd0, bus.ex_imm_sel}, 32'd0);
`ifdef ALU_STALL_CNT_EN
    checkOutput("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1,  3,  0,  5, 1, 0, 1, 0, 0, 0, 0);

`ifdef ALU_STALL_CNT_EN
    @(negedge clk);
    dut.stall_cnt_q = 16'hFFFD;
    loadUsePair(5'd20);
    loadUsePair(5'd21);
    loadUsePair(5'd22);
    checkOutput("stall_cnt_saturate", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
